// File: rtl/pid_prog_sequencer_pkg.sv
// Shared types and constants for the PID program sequencer.
package sloth_pid_pkg;

    localparam int unsigned DEPTH   = 16;
    localparam int unsigned ADDR_W  = $clog2(DEPTH);
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned INSTR_W = 7;
    localparam int unsigned NREGS   = 4;

    localparam int unsigned OP_MSB  = 6;
    localparam int unsigned OP_LSB  = 4;
    localparam int unsigned DST_MSB = 3;
    localparam int unsigned DST_LSB = 2;
    localparam int unsigned SRC_MSB = 1;
    localparam int unsigned SRC_LSB = 0;

    typedef enum logic [2:0] {
        OP_NOP = 3'd0,
        OP_MOV = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_NOT = 3'd5,
        OP_ADD = 3'd6,
        OP_SUB = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/pid_prog_sequencer_if.sv
// Host / datapath side bundle of the program sequencer.
interface pid_prog_sequencer_if;
    import sloth_pid_pkg::*;

    logic                 prog_we;
    logic [ADDR_W-1:0]    prog_addr;
    logic [INSTR_W-1:0]   prog_data;
    logic [ADDR_W:0]      prog_len;
    logic                 start;
    logic [DATA_W-1:0]    a0;
    logic [DATA_W-1:0]    a1;
    logic [DATA_W-1:0]    b0;
    logic [DATA_W-1:0]    b1;
    logic                 busy;
    logic                 done;
    logic [DATA_W-1:0]    y0;
    logic [DATA_W-1:0]    y1;
    logic [DATA_W-1:0]    y2;
    logic [DATA_W-1:0]    y3;

    modport master (
        output prog_we, prog_addr, prog_data, prog_len, start, a0, a1, b0, b1,
        input  busy, done, y0, y1, y2, y3
    );

    modport slave (
        input  prog_we, prog_addr, prog_data, prog_len, start, a0, a1, b0, b1,
        output busy, done, y0, y1, y2, y3
    );
endinterface

// File: rtl/pid_prog_alu.sv
// Single-instruction ALU: combines destination and source register values.
module pid_prog_alu
    import sloth_pid_pkg::*;
(
    input  op_e               op,
    input  logic [DATA_W-1:0] rd,
    input  logic [DATA_W-1:0] rs,
    output logic [DATA_W-1:0] res_c
);

    // Opcode decode; NOT is logical (zero test), ADD/SUB wrap
    always_comb begin
        res_c = rd;
        case (op)
            OP_NOP: res_c = rd;
            OP_MOV: res_c = rs;
            OP_AND: res_c = rd & rs;
            OP_OR:  res_c = rd | rs;
            OP_XOR: res_c = rd ^ rs;
            OP_NOT: res_c = (rs == '0) ? DATA_W'(1) : '0;
            OP_ADD: res_c = rd + rs;
            OP_SUB: res_c = rd - rs;
        endcase
    end

endmodule

// File: rtl/pid_prog_sequencer.sv
// Micro-sequencer executing one program-memory instruction per clock
// over a four-entry register file loaded from the operand inputs.
module pid_prog_sequencer
    import sloth_pid_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    pid_prog_sequencer_if.slave  bus
);

    localparam int unsigned LEN_W = ADDR_W + 1;

    state_e               state, state_n;
    logic [ADDR_W-1:0]    pc, pc_n;
    logic [LEN_W-1:0]     len, len_n, len_clamp_c;
    logic [DATA_W-1:0]    r     [NREGS];
    logic [DATA_W-1:0]    r_n   [NREGS];
    logic [DATA_W-1:0]    y_q   [NREGS];
    logic [DATA_W-1:0]    y_n   [NREGS];
    logic                 busy_q, busy_n;
    logic                 done_q, done_n;
    logic                 mem_we;
    logic [INSTR_W-1:0]   mem   [DEPTH];
    logic [INSTR_W-1:0]   instr;
    op_e                  op;
    logic [1:0]           dst, src;
    logic [DATA_W-1:0]    alu_res;

    assign instr = mem[pc];
    assign op    = op_e'(instr[OP_MSB:OP_LSB]);
    assign dst   = instr[DST_MSB:DST_LSB];
    assign src   = instr[SRC_MSB:SRC_LSB];

    assign len_clamp_c = (bus.prog_len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : bus.prog_len;

    pid_prog_alu u_alu (
        .op    (op),
        .rd    (r[dst]),
        .rs    (r[src]),
        .res_c (alu_res)
    );

    // Program memory write port; contents survive reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[bus.prog_addr] <= bus.prog_data;
        end
    end

    // State, pc, register file and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            pc     <= '0;
            len    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                r[i]   <= '0;
                y_q[i] <= '0;
            end
        end else begin
            state  <= state_n;
            pc     <= pc_n;
            len    <= len_n;
            busy_q <= busy_n;
            done_q <= done_n;
            r      <= r_n;
            y_q    <= y_n;
        end
    end

    // Next-state, register-file update and program-write acceptance
    always_comb begin
        state_n = state;
        pc_n    = pc;
        len_n   = len;
        r_n     = r;
        y_n     = y_q;
        mem_we  = 1'b0;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    r_n[0] = bus.a0;
                    r_n[1] = bus.a1;
                    r_n[2] = bus.b0;
                    r_n[3] = bus.b1;
                    len_n  = len_clamp_c;
                    pc_n   = '0;
                    if (len_clamp_c == '0) begin
                        y_n     = r_n;
                        state_n = DONE;
                    end else begin
                        state_n = EXEC;
                    end
                end else if (bus.prog_we) begin
                    mem_we = 1'b1;
                end
            end
            EXEC: begin
                r_n[dst] = alu_res;
                pc_n     = pc + ADDR_W'(1);
                if ({1'b0, pc} == (len - LEN_W'(1))) begin
                    y_n     = r_n;
                    state_n = DONE;
                end
            end
            DONE: begin
                state_n = IDLE;
                mem_we  = bus.prog_we;
            end
            default: state_n = IDLE;
        endcase

        busy_n = (state_n == EXEC);
        done_n = (state_n == DONE);
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.y0   = y_q[0];
    assign bus.y1   = y_q[1];
    assign bus.y2   = y_q[2];
    assign bus.y3   = y_q[3];

endmodule

// File: tb/tb_pid_prog_sequencer.sv
// Bench for pid_prog_sequencer: run-level reference model plus directed runs.
module tb_pid_prog_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;

    pid_prog_sequencer_if bus();

    pid_prog_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int vec  = 0;
    int errs = 0;

    // Reference model: a whole run is evaluated when it is accepted,
    // then the result is released after len cycles of busy.
    int          m_cnt  = 0;
    int          m_len  = 0;
    bit          m_done = 1'b0;
    logic [15:0] m_r [4];
    logic [15:0] m_y [4] = '{default: 16'h0};
    logic [6:0]  shadow [16];
    bit          was_idle, was_busy, accept;

    task automatic model_exec();
        logic [6:0] ins;
        int d, s;
        for (int i = 0; i < m_len; i++) begin
            ins = shadow[i];
            d = int'(ins[3:2]);
            s = int'(ins[1:0]);
            case (ins[6:4])
                3'd1: m_r[d] = m_r[s];
                3'd2: m_r[d] = m_r[d] & m_r[s];
                3'd3: m_r[d] = m_r[d] | m_r[s];
                3'd4: m_r[d] = m_r[d] ^ m_r[s];
                3'd5: m_r[d] = (m_r[s] == 16'h0) ? 16'h0001 : 16'h0000;
                3'd6: m_r[d] = m_r[d] + m_r[s];
                3'd7: m_r[d] = m_r[d] - m_r[s];
                default: ;
            endcase
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt  = 0;
            m_done = 1'b0;
            for (int i = 0; i < 4; i++) m_y[i] = 16'h0;
        end else begin
            was_busy = (m_cnt != 0);
            was_idle = !was_busy && !m_done;
            accept   = was_idle && bus.start;
            if (accept) begin
                m_len = (int'(bus.prog_len) > 16) ? 16 : int'(bus.prog_len);
                m_r[0] = bus.a0;
                m_r[1] = bus.a1;
                m_r[2] = bus.b0;
                m_r[3] = bus.b1;
                model_exec();
                if (m_len == 0) begin
                    m_y    = m_r;
                    m_done = 1'b1;
                end else begin
                    m_cnt = m_len;
                end
            end else if (was_busy) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_y    = m_r;
                    m_done = 1'b1;
                end
            end else if (m_done) begin
                m_done = 1'b0;
            end
            if (bus.prog_we && !was_busy && !accept) begin
                shadow[bus.prog_addr] = bus.prog_data;
            end
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        vec++;
        if (bus.busy !== (m_cnt != 0) || bus.done !== m_done ||
            bus.y0 !== m_y[0] || bus.y1 !== m_y[1] ||
            bus.y2 !== m_y[2] || bus.y3 !== m_y[3]) begin
            errs++;
            $display("FAIL cycle t=%0t: busy=%b done=%b y=%h %h %h %h, required busy=%b done=%b y=%h %h %h %h",
                     $time, bus.busy, bus.done, bus.y0, bus.y1, bus.y2, bus.y3,
                     (m_cnt != 0), m_done, m_y[0], m_y[1], m_y[2], m_y[3]);
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vec++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    task automatic wr(input logic [3:0] addr, input logic [6:0] data);
        @(negedge clk);
        bus.prog_we   = 1'b1;
        bus.prog_addr = addr;
        bus.prog_data = data;
        @(negedge clk);
        bus.prog_we   = 1'b0;
    endtask

    // mode 0: plain run; 1: start+write pulsed while busy; 2: write together with start
    task automatic run(input logic [15:0] x0, input logic [15:0] x1,
                       input logic [15:0] x2, input logic [15:0] x3,
                       input logic [4:0] len, input int mode, output int cyc);
        int nd;
        @(negedge clk);
        bus.a0 = x0; bus.a1 = x1; bus.b0 = x2; bus.b1 = x3;
        bus.prog_len = len;
        bus.start    = 1'b1;
        if (mode == 2) begin
            bus.prog_we   = 1'b1;
            bus.prog_addr = 4'd0;
            bus.prog_data = 7'b0011000;
        end
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.prog_we = 1'b0;
        bus.a0 = ~x0; bus.a1 = ~x1; bus.b0 = ~x2; bus.b1 = ~x3;
        bus.prog_len = 5'd3;
        cyc = 0;
        nd  = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bus.done) begin
                nd++;
                if (cyc == 0) cyc = k;
            end
            if (mode == 1 && k == 2) begin
                bus.start     = 1'b1;
                bus.prog_we   = 1'b1;
                bus.prog_addr = 4'd0;
                bus.prog_data = 7'b0011000;
            end else if (mode == 1 && k == 3) begin
                bus.start   = 1'b0;
                bus.prog_we = 1'b0;
            end
            if (cyc != 0 && k >= cyc + 2) break;
        end
        check("done_pulse_count", 32'(nd), 32'd1);
    endtask

    task automatic load_evolved();
        wr(4'd0, 7'b0100011);   // AND r0,r3
        wr(4'd1, 7'b1010100);   // NOT r1,r0
        wr(4'd2, 7'b1011111);   // NOT r3,r3
        wr(4'd3, 7'b0100001);   // AND r0,r1
    endtask

    task automatic check_y(input string tag, input logic [15:0] e0, input logic [15:0] e1,
                           input logic [15:0] e2, input logic [15:0] e3);
        check({tag, "_y0"}, 32'(bus.y0), 32'(e0));
        check({tag, "_y1"}, 32'(bus.y1), 32'(e1));
        check({tag, "_y2"}, 32'(bus.y2), 32'(e2));
        check({tag, "_y3"}, 32'(bus.y3), 32'(e3));
    endtask

    int c;
    int nd_after;

    initial begin
        bus.prog_we = 1'b0; bus.prog_addr = '0; bus.prog_data = '0;
        bus.prog_len = '0; bus.start = 1'b0;
        bus.a0 = '0; bus.a1 = '0; bus.b0 = '0; bus.b1 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check_y("reset", 16'h0, 16'h0, 16'h0, 16'h0);

        load_evolved();
        run(16'hFFFF, 16'h5555, 16'h1234, 16'h00F0, 5'd4, 0, c);
        check("evolved_latency", 32'(c), 32'd5);
        check_y("evolved", 16'h0000, 16'h0000, 16'h1234, 16'h0000);

        run(16'h0001, 16'h5555, 16'h1234, 16'h0000, 5'd4, 0, c);
        check_y("evolved_b", 16'h0000, 16'h0001, 16'h1234, 16'h0001);

        run(16'hFFFF, 16'h5555, 16'h1234, 16'h00F0, 5'd4, 1, c);
        check("inject_latency", 32'(c), 32'd5);
        check_y("inject", 16'h0000, 16'h0000, 16'h1234, 16'h0000);
        run(16'hFFFF, 16'h5555, 16'h1234, 16'h00F0, 5'd4, 0, c);
        check_y("rerun_after_inject", 16'h0000, 16'h0000, 16'h1234, 16'h0000);

        run(16'hFFFF, 16'h5555, 16'h1234, 16'h00F0, 5'd4, 2, c);
        run(16'hFFFF, 16'h5555, 16'h1234, 16'h00F0, 5'd4, 0, c);
        check_y("write_with_start_dropped", 16'h0000, 16'h0000, 16'h1234, 16'h0000);

        wr(4'd0, 7'b1100001);   // ADD r0,r1
        run(16'hFFFF, 16'h0002, 16'h0000, 16'h0000, 5'd1, 0, c);
        check("add_latency", 32'(c), 32'd2);
        check("add_wrap", 32'(bus.y0), 32'h0001);
        wr(4'd0, 7'b1110001);   // SUB r0,r1
        run(16'h0000, 16'h0001, 16'h0000, 16'h0000, 5'd1, 0, c);
        check("sub_wrap", 32'(bus.y0), 32'hFFFF);

        run(16'h1111, 16'h2222, 16'h3333, 16'h4444, 5'd0, 0, c);
        check("len0_latency", 32'(c), 32'd1);
        check_y("len0", 16'h1111, 16'h2222, 16'h3333, 16'h4444);

        for (int i = 0; i < 16; i++) wr(4'(i), 7'b1100001);
        run(16'h0000, 16'h0001, 16'h0000, 16'h0000, 5'd31, 0, c);
        check("clamp_latency", 32'(c), 32'd17);
        check("clamp_y0", 32'(bus.y0), 32'h0010);

        @(negedge clk);
        bus.a0 = 16'h0; bus.a1 = 16'h1; bus.b0 = 16'h0; bus.b1 = 16'h0;
        bus.prog_len = 5'd16;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_busy", 32'(bus.busy), 32'd0);
        check("async_rst_done", 32'(bus.done), 32'd0);
        check_y("async_rst", 16'h0, 16'h0, 16'h0, 16'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        nd_after = 0;
        repeat (25) begin
            @(negedge clk);
            if (bus.done) nd_after++;
        end
        check("no_done_after_reset", 32'(nd_after), 32'd0);

        load_evolved();
        run(16'hFFFF, 16'h5555, 16'h1234, 16'h00F0, 5'd4, 0, c);
        check("post_reset_latency", 32'(c), 32'd5);
        check_y("post_reset", 16'h0000, 16'h0000, 16'h1234, 16'h0000);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
